// File: rtl/ram_arbiter_if.sv
// Shared types and bundled port signals for ram_arbiter.
// The package holds the RAM control encodings used by the core and the RAM;
// the interface groups the fetch port, the load/store port and the RAM side.

package ram_arbiter_pkg;

    // RAM operation: a write happens only on MEM_STORE.
    typedef enum logic {
        MEM_LOAD  = 1'b0,
        MEM_STORE = 1'b1
    } mem_op_e;

    // Access size: byte, halfword or word.
    typedef enum logic [1:0] {
        RAM_MASK_B = 2'd0,
        RAM_MASK_H = 2'd1,
        RAM_MASK_W = 2'd2
    } ram_mask_e;

endpackage

interface ram_arbiter_if;
    import ram_arbiter_pkg::*;

    // Instruction-fetch port
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_err;

    // Load/store port
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    ram_mask_e   d_mask;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    // RAM side
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    mem_op_e     ram_mem_op;
    ram_mask_e   ram_mask;
    logic [31:0] ram_rdata;

    // The arbiter itself.
    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata, d_mask,
        input  ram_rdata,
        output i_gnt, i_rvalid, i_rdata, i_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output ram_addr, ram_wdata, ram_mem_op, ram_mask
    );

    // The requesters and the RAM surrounding the arbiter.
    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata, d_mask,
        output ram_rdata,
        input  i_gnt, i_rvalid, i_rdata, i_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  ram_addr, ram_wdata, ram_mem_op, ram_mask
    );

endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port, byte-addressed RAM between the
// instruction-fetch port (I) and the load/store port (D) of the rv32i core.
// One access per cycle, round-robin on contention. Misaligned or out-of-range
// accesses are still granted but never reach the RAM as a write and answer
// with err = 1. Responses appear exactly one cycle after the grant.

module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_arbiter_if.slave bus
);

    // Which port won most recently; the other one wins the next tie.
    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

    // Round-robin state
    port_e       rr_last_q;
    port_e       rr_last_d;

    // Grants for this cycle
    logic        grant_i;
    logic        grant_d;

    // Access presented to the RAM this cycle
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    ram_mask_e   sel_mask;
    logic        sel_store;

    // Legality of the selected access
    logic [32:0] sel_size;
    logic [32:0] end_addr;
    logic        mask_ok;
    logic        misaligned;
    logic        out_of_range;
    logic        illegal;

    // Per-port response registers
    logic        i_rvalid_q;
    logic        i_rvalid_d;
    logic [31:0] i_rdata_q;
    logic [31:0] i_rdata_d;
    logic        i_err_q;
    logic        i_err_d;
    logic        d_rvalid_q;
    logic        d_rvalid_d;
    logic [31:0] d_rdata_q;
    logic [31:0] d_rdata_d;
    logic        d_err_q;
    logic        d_err_d;

    // Arbitration: a lone request wins; a tie goes to the port not granted last.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        rr_last_d = rr_last_q;

        unique case ({bus.i_req, bus.d_req})
            2'b10: grant_i = 1'b1;
            2'b01: grant_d = 1'b1;
            2'b11: begin
                if (rr_last_q == PORT_D) begin
                    grant_i = 1'b1;
                end else begin
                    grant_d = 1'b1;
                end
            end
            default: ;
        endcase

        if (grant_i) begin
            rr_last_d = PORT_I;
        end else if (grant_d) begin
            rr_last_d = PORT_D;
        end
    end

    // Round-robin pointer; reset to D so that I wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q <= PORT_D;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            rr_last_q <= rr_last_d;
        end
    end

    // Steer the granted port's payload; idle cycles present a harmless word read of 0.
    always_comb begin
        sel_addr  = 32'd0;
        sel_wdata = 32'd0;
        sel_mask  = RAM_MASK_W;
        sel_store = 1'b0;

        if (grant_d) begin
            sel_addr  = bus.d_addr;
            sel_wdata = bus.d_wdata;
            sel_mask  = bus.d_mask;
            sel_store = bus.d_we;
        end else if (grant_i) begin
            // Fetches are always word-sized reads.
            sel_addr  = bus.i_addr;
        end
    end

    // Alignment and range checks on the selected access.
    always_comb begin
        sel_size   = 33'd4;
        mask_ok    = 1'b1;
        misaligned = 1'b0;

        unique case (sel_mask)
            RAM_MASK_B: begin
                sel_size   = 33'd1;
            end
            RAM_MASK_H: begin
                sel_size   = 33'd2;
                misaligned = sel_addr[0];
            end
            RAM_MASK_W: begin
                sel_size   = 33'd4;
                misaligned = (sel_addr[1:0] != 2'b00);
            end
            default: begin
                // Unused encoding: never let it touch the RAM.
                mask_ok    = 1'b0;
            end
        endcase

        // The last byte touched must lie inside the RAM; checking the end
        // address also covers a start address that is already out of range,
        // and stops the RAM from wrapping an access around to address 0.
        end_addr     = {1'b0, sel_addr} + sel_size - 33'd1;
        out_of_range = |(end_addr >> ADDR_WIDTH);

        illegal      = misaligned | out_of_range | !mask_ok;
    end

    // RAM drive: only a granted, legal store may write.
    assign bus.ram_addr   = sel_addr;
    assign bus.ram_wdata  = sel_wdata;
    assign bus.ram_mask   = sel_mask;
    assign bus.ram_mem_op = (sel_store && !illegal) ? MEM_STORE : MEM_LOAD;

    // Next response per port: valid only after a grant; rejected accesses return 0.
    always_comb begin
        i_rvalid_d = grant_i;
        i_rdata_d  = i_rdata_q;
        i_err_d    = i_err_q;
        d_rvalid_d = grant_d;
        d_rdata_d  = d_rdata_q;
        d_err_d    = d_err_q;

        // The RAM read is combinational and sampled at the same edge as any
        // write, so a store's response carries the word before the write.
        if (grant_i) begin
            i_rdata_d = illegal ? 32'd0 : bus.ram_rdata;
            i_err_d   = illegal;
        end

        if (grant_d) begin
            d_rdata_d = illegal ? 32'd0 : bus.ram_rdata;
            d_err_d   = illegal;
        end
    end

    // Response registers; reset drops any response still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_rvalid_q <= 1'b0;
            i_rdata_q  <= 32'd0;
            i_err_q    <= 1'b0;
            d_rvalid_q <= 1'b0;
            d_rdata_q  <= 32'd0;
            d_err_q    <= 1'b0;
        end else begin
            i_rvalid_q <= i_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            i_err_q    <= i_err_d;
            d_rvalid_q <= d_rvalid_d;
            d_rdata_q  <= d_rdata_d;
            d_err_q    <= d_err_d;
        end
    end

    // Port outputs
    assign bus.i_gnt    = grant_i;
    assign bus.d_gnt    = grant_d;
    assign bus.i_rvalid = i_rvalid_q;
    assign bus.i_rdata  = i_rdata_q;
    assign bus.i_err    = i_err_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.d_err    = d_err_q;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single-port byte-addressed data/instruction RAM between the instruction-fetch port (I) and the load/store port (D) of the rv32i core. It arbitrates round-robin, one access per cycle, and drives the RAM's addr/wdata/mem_op/ram_mask. It registers the RAM's combinational read data into per-port responses with a fixed one-cycle latency. It rejects misaligned or out-of-range accesses before they reach the RAM.

## Interface
Parameters:
- ADDR_WIDTH, 14, RAM byte-address width; valid addresses are 0 .. 2^ADDR_WIDTH-1

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; held with i_addr until i_gnt
- i_addr  in  32  fetch byte address
- i_gnt  out  1  fetch accepted this cycle (combinational)
- i_rvalid  out  1  fetch response valid (registered)
- i_rdata  out  32  fetch data, valid with i_rvalid
- i_err  out  1  fetch rejected, valid with i_rvalid
- d_req  in  1  load/store request; held with its payload until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  byte address
- d_wdata  in  32  store data, LSB-aligned
- d_mask  in  ram_mask_e  RAM_MASK_B/H/W access size
- d_gnt  out  1  load/store accepted this cycle (combinational)
- d_rvalid  out  1  load/store response valid (registered); also pulses for stores
- d_rdata  out  32  raw little-endian word at d_addr; the core extracts and extends by size
- d_err  out  1  access rejected, valid with d_rvalid
- ram_addr  out  32  to RAM addr
- ram_wdata  out  32  to RAM wdata
- ram_mem_op  out  mem_op_e  to RAM mem_op; MEM_STORE only on an accepted, legal store; MEM_LOAD otherwise
- ram_mask  out  ram_mask_e  to RAM ram_mask; RAM_MASK_W for fetches
- ram_rdata  in  32  from RAM rdata (combinational read)

## Operation
- State:
  - rr_last, 1 bit: last granted port, 0 = I, 1 = D.
  - Response registers per port: rvalid, rdata, err.
- Arbitration, combinational each cycle:
  - Only one request: grant it.
  - Both requesting: grant the port that is not rr_last.
  - rr_last updates to the granted port on the edge.
- Selected port's address, wdata and mask drive the RAM.
- When nothing is granted:
  - ram_addr = 0
  - ram_mem_op = MEM_LOAD
  - ram_mask = RAM_MASK_W
- Legality of a granted access; illegal if any of:
  - d_mask H with addr[0] = 1;
  - W, or any fetch, with addr[1:0] != 0;
  - addr >= 2^ADDR_WIDTH, or (addr + size - 1) >= 2^ADDR_WIDTH, which blocks the RAM's internal wrap.
- Illegal accesses:
  - Still granted and consume the slot.
  - Drive ram_mem_op = MEM_LOAD, so the RAM is never written.
  - Respond with err = 1 and rdata = 0.
- Legal grants capture ram_rdata into the port's rdata on the edge, with err = 0.
- Legal stores:
  - ram_mem_op = MEM_STORE; the RAM writes at the same edge.
  - The response carries the pre-write word in rdata.
- A port whose grant was 0 has rvalid = 0 next cycle.
- A port may hold req high continuously; with no contention it is granted every cycle.

## Timing
- Reset, asynchronous: rr_last = 1 (I wins the first tie).
  - i_rvalid = d_rvalid = i_err = d_err = 0.
  - i_rdata = d_rdata = 0.
  - Grants are combinational from req, so they are 0 while both reqs are 0.
- Latency: grant in cycle N produces rvalid/rdata/err in cycle N+1, for exactly one cycle.
- Throughput: one access per cycle total.
- Under continuous contention the ports alternate I, D, I, D.
- Read data is sampled before the write takes effect, so a store's response shows the old word.
- A load granted in the cycle after a store to the same address sees the new data.
- Reset asserted mid-operation: any pending response is dropped; no rvalid appears after reset release.
- Requesters must not change payload while req = 1 and gnt = 0; behaviour is undefined otherwise.

## Test plan
- Reset, then I fetch at 0x0 with RAM word 0x00000013 → i_gnt same cycle; next cycle i_rvalid = 1, i_rdata = 0x00000013, i_err = 0.
- Both request continuously for 6 cycles from reset → grant order I, D, I, D, I, D; each port sees rvalid in alternate cycles.
- D store W 0xDEADBEEF at 0x100, then load W at 0x100 next cycle → store response rdata = old word, err = 0; load response rdata = 0xDEADBEEF.
- D store H at 0x101 → d_err = 1, RAM contents unchanged at 0x100..0x103.
- D store B at 0x102 → only byte 0x102 changes.
- D load W at 0x3FFE (ADDR_WIDTH = 14) → d_err = 1; D load W at 0x4000 → d_err = 1, ram_mem_op never MEM_STORE.
- Assert rst_n low in the cycle after a grant → no rvalid after release; next tie granted to I.
